frame_sample_loader: RTL

Upstream stage of the 51-tap moving-average filter. It accepts a serial stream of 8-bit samples over a valid/ready handshake and packs them into a 256-entry frame register array. When the frame is complete it issues a one-cycle start pulse to the filter. It then holds the frame stable and refuses new samples until the filter reports ready.

---
 rtl/filt_pkg.sv | 12 +
 rtl/frame_sample_loader.sv | 80 ++++++++
 2 files changed

// File: rtl/filt_pkg.sv
// Shared types for the moving-average filter and its upstream sample loader.
package filt_pkg;

  localparam int FRAME_DEPTH = 256;
  localparam int SAMPLE_W    = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef sample_t [0:FRAME_DEPTH-1] frame_t;

  typedef enum logic [1:0] {FILL, LAUNCH, WAIT} ldr_state_e;

endpackage

// File: rtl/frame_sample_loader.sv
// Packs a valid/ready sample stream into a frame, pulses start_flg to the filter,
// then holds the frame until the filter reports ready again.
module frame_sample_loader
  import filt_pkg::*;
#(
  parameter int DEPTH = FRAME_DEPTH,
  parameter int DW    = SAMPLE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [DW-1:0]            s_data,
  output logic                     s_ready,
  output logic [0:DEPTH-1][DW-1:0] frame_out,
  output logic                     start_flg,
  input  logic                     filt_rdy,
  output logic [7:0]               frame_id,
  output logic                     busy
);

  localparam int IW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  ldr_state_e    state;
  logic [IW-1:0] wr_idx;
  logic          xfer;

  assign xfer = s_valid && s_ready;

  // Outputs are registered alongside the state so s_ready never depends on s_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      wr_idx    <= '0;
      frame_id  <= '0;
      frame_out <= '0;
      s_ready   <= 1'b1;
      start_flg <= 1'b0;
      busy      <= 1'b0;
    end else begin
      start_flg <= 1'b0;
      unique case (state)
        FILL: begin
          if (xfer) begin
            frame_out[wr_idx[AW-1:0]] <= s_data;
            if (wr_idx == LAST_IDX) begin
              wr_idx    <= '0;
              state     <= LAUNCH;
              s_ready   <= 1'b0;
              start_flg <= 1'b1;
              busy      <= 1'b1;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        // The filter's ready flag is sticky, so anything seen during LAUNCH is stale.
        LAUNCH: begin
          state    <= WAIT;
          frame_id <= frame_id + 8'd1;
        end
        WAIT: begin
          if (filt_rdy) begin
            state   <= FILL;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= FILL;
          wr_idx  <= '0;
          s_ready <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
